// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Bundles the three signal groups of the ALU sequencer:
//     cmd_*  : command push channel (valid/ready) into the sequencer FIFO
//     alu_*  : control/operand bus to the external ALU and its result return
//     rsp_*  : response channel (valid/ready) out of the sequencer, plus busy
//   Modports:
//     slave  : the sequencer side (consumes commands, drives ALU and responses)
//     master : the environment side (issues commands, models the ALU, takes responses)
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;

  logic             alu_on;
  logic [2:0]       alu_in_sel;
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  alu_result, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
    output rsp_valid, rsp_data, rsp_error, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output alu_result, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
    input  rsp_valid, rsp_data, rsp_error, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Queues ALU commands in a small FIFO and runs them one at a time through an
//   external multi-cycle ALU, returning each result on a valid/ready response
//   channel. A command may chain, using the previous result as operand A.
//   Ports:
//     clk  : single rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : alu_sequencer_if.slave (cmd_*, alu_*, rsp_*, busy)
//   All bus outputs except cmd_ready are registered; cmd_ready decodes only
//   the registered FIFO count.
module alu_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  // alu_in_sel one-hot {persist, load, reset}
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  localparam logic [2:0] OP_MULT    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [WIDTH-1:0] DATA_ZERO = WIDTH'(0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Command opcode to ALU output-select one-hot; bit 6 = and ... bit 0 = mult.
  // The opcode order (xor before not) differs from the select bit order.
  function automatic logic [6:0] op_to_sel(input logic [2:0] op);
    logic [6:0] sel;
    case (op)
      3'd0:    sel = 7'b1000000; // and
      3'd1:    sel = 7'b0100000; // or
      3'd2:    sel = 7'b0001000; // xor
      3'd3:    sel = 7'b0010000; // not
      3'd4:    sel = 7'b0000100; // add
      3'd5:    sel = 7'b0000010; // sub
      3'd6:    sel = 7'b0000001; // mult
      default: sel = 7'b0000000; // illegal
    endcase
    return sel;
  endfunction

  // FIFO storage and bookkeeping
  logic [2:0]       fifo_op    [DEPTH];
  logic [WIDTH-1:0] fifo_a     [DEPTH];
  logic [WIDTH-1:0] fifo_b     [DEPTH];
  logic             fifo_chain [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  logic [2:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_chain;

  // Sequencer state
  state_t           state;
  state_t           state_next;
  logic [2:0]       cur_op;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_done;
  logic [WIDTH-1:0] last_res;

  // Registered ALU outputs and their next values
  logic             alu_on_r;
  logic [2:0]       in_sel_r;
  logic [2:0]       in_sel_next;
  logic [WIDTH-1:0] num1_r;
  logic [WIDTH-1:0] num1_next;
  logic [WIDTH-1:0] num2_r;
  logic [WIDTH-1:0] num2_next;
  logic [6:0]       out_sel_r;
  logic [6:0]       out_sel_next;

  // Registered response outputs
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_error_r;
  logic             busy_r;

  assign bus.cmd_ready = (count != CNT_FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;

  assign head_op    = fifo_op[rd_ptr];
  assign head_a     = fifo_a[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign head_chain = fifo_chain[rd_ptr];

  assign lat_done = (lat_cnt == LAT_LAST);

  assign bus.alu_on      = alu_on_r;
  assign bus.alu_in_sel  = in_sel_r;
  assign bus.alu_num1    = num1_r;
  assign bus.alu_num2    = num2_r;
  assign bus.alu_out_sel = out_sel_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_error   = rsp_error_r;
  assign bus.busy        = busy_r;

  // FIFO payload write; storage needs no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]    <= bus.cmd_op;
      fifo_a[wr_ptr]     <= bus.cmd_a;
      fifo_b[wr_ptr]     <= bus.cmd_b;
      fifo_chain[wr_ptr] <= bus.cmd_chain;
    end
  end

  // FIFO occupancy next value from simultaneous push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // FIFO pointer and count registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // FSM next state, FIFO pop, and next values for the registered ALU bus
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    in_sel_next  = SEL_PERSIST;
    num1_next    = DATA_ZERO;
    num2_next    = DATA_ZERO;
    out_sel_next = 7'b0000000;

    case (state)
      IDLE: begin
        if (count != CNT_ZERO) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (cur_op == OP_ILLEGAL) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_done) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are computed for the state being entered so they can be
    // registered and still line up with that state.
    case (state_next)
      ISSUE: begin
        // ISSUE is only entered from IDLE with a pop, so the head is the command
        if (head_op != OP_ILLEGAL) begin
          in_sel_next  = SEL_LOAD;
          num1_next    = head_chain ? last_res : head_a;
          num2_next    = head_b;
          out_sel_next = op_to_sel(head_op);
        end else begin
          in_sel_next  = SEL_PERSIST;
        end
      end
      WAIT: begin
        in_sel_next  = SEL_PERSIST;
        num1_next    = num1_r;
        num2_next    = num2_r;
        out_sel_next = out_sel_r;
      end
      default: begin
        in_sel_next  = SEL_PERSIST;
      end
    endcase
  end

  // FSM state, current opcode and ALU latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_op  <= 3'd0;
      lat_cnt <= LAT_ZERO;
    end else begin
      state <= state_next;
      if (pop) begin
        cur_op <= head_op;
      end
      if ((state == WAIT) && !lat_done) begin
        lat_cnt <= lat_cnt + LAT_ONE;
      end else begin
        lat_cnt <= LAT_ZERO;
      end
    end
  end

  // Registered ALU control bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_on_r  <= 1'b0;
      in_sel_r  <= SEL_RESET;
      num1_r    <= DATA_ZERO;
      num2_r    <= DATA_ZERO;
      out_sel_r <= 7'b0000000;
    end else begin
      alu_on_r  <= 1'b1;
      in_sel_r  <= in_sel_next;
      num1_r    <= num1_next;
      num2_r    <= num2_next;
      out_sel_r <= out_sel_next;
    end
  end

  // Result capture, response channel and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_res    <= DATA_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= DATA_ZERO;
      rsp_error_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if ((state == ISSUE) && (cur_op == OP_ILLEGAL)) begin
        // Illegal opcode never reaches the ALU and leaves last_res alone
        rsp_data_r  <= DATA_ZERO;
        rsp_error_r <= 1'b1;
      end else if ((state == WAIT) && lat_done) begin
        // Overflow is only meaningful for mult; other ops ignore the flag
        rsp_data_r  <= bus.alu_result;
        rsp_error_r <= (cur_op == OP_MULT) && bus.alu_overflow;
        last_res    <= bus.alu_result;
      end
      rsp_valid_r <= (state_next == RESP);
      busy_r      <= (state_next != IDLE) || (count_next != CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed self-checking bench for alu_sequencer (WIDTH=8, DEPTH=4,
//   ALU_LAT=1). Includes a one-cycle behavioural ALU that loads on
//   alu_in_sel=load and counts loads. Expected values are hand-computed.
module tb_alu_sequencer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: latches result one edge after seeing load
  logic [W-1:0] m_res = 8'h00;
  logic         m_ovf = 1'b0;
  int           load_cnt = 0;

  assign bus.alu_result   = m_res;
  assign bus.alu_overflow = m_ovf;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [6:0] sel);
    logic [15:0] p;
    logic [8:0]  r;
    p = 16'h0000;
    case (sel)
      7'b1000000: r = {1'b0, a & b};
      7'b0100000: r = {1'b0, a | b};
      7'b0010000: r = {1'b0, ~a};
      7'b0001000: r = {1'b0, a ^ b};
      7'b0000100: begin p = {8'h00, a} + {8'h00, b}; r = {p[8], p[7:0]}; end
      7'b0000010: begin p = {8'h00, a} - {8'h00, b}; r = {p[8], p[7:0]}; end
      7'b0000001: begin p = {8'h00, a} * {8'h00, b}; r = {|p[15:8], p[7:0]}; end
      default:    r = {1'b0, 8'hEE};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.alu_on && (bus.alu_in_sel == 3'b010)) begin
      {m_ovf, m_res} <= alu_f(bus.alu_num1, bus.alu_num2, bus.alu_out_sel);
      load_cnt       <= load_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'h0);
    check_eq({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'h0);
    check_eq({tag, "_alu_on"}, 32'(bus.alu_on), 32'h0);
    check_eq({tag, "_in_sel"}, 32'(bus.alu_in_sel), 32'h1);
    check_eq({tag, "_num1"}, 32'(bus.alu_num1), 32'h0);
    check_eq({tag, "_num2"}, 32'(bus.alu_num2), 32'h0);
    check_eq({tag, "_out_sel"}, 32'(bus.alu_out_sel), 32'h0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  // Offer one command and return after its handshake edge
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain);
    int n;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = chain;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 32'h1, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, check it, and complete the handshake
  task automatic expect_rsp(input string tag, input logic [7:0] data, input logic err);
    int n;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'h1);
    check_eq({tag, "_data"}, 32'(bus.rsp_data), 32'(data));
    check_eq({tag, "_err"}, 32'(bus.rsp_error), 32'(err));
    tick();
  endtask

  // Directed op vectors: op, a, b, expected data, expected error
  logic [2:0] v_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd6};
  logic [7:0] v_a   [8] = '{8'hF0, 8'hF0, 8'hAA, 8'h0F, 8'h05, 8'hFF, 8'h20, 8'h03};
  logic [7:0] v_b   [8] = '{8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h07, 8'h02, 8'h10, 8'h04};
  logic [7:0] v_res [8] = '{8'h30, 8'hFF, 8'h55, 8'hF0, 8'hFE, 8'h01, 8'h00, 8'h0C};
  logic       v_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int accepted;
    int seen;
    int lc;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_chain = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'h1);
    tick();
    check_eq("alu_on_run", 32'(bus.alu_on), 32'h1);
    check_eq("idle_in_sel", 32'(bus.alu_in_sel), 32'h4);

    // Latency and ISSUE/WAIT/RESP bus values: add 05+03
    bus.rsp_ready = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_a     = 8'h05;
    bus.cmd_b     = 8'h03;
    bus.cmd_chain = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        check_eq("issue_in_sel", 32'(bus.alu_in_sel), 32'h2);
        check_eq("issue_num1", 32'(bus.alu_num1), 32'h05);
        check_eq("issue_num2", 32'(bus.alu_num2), 32'h03);
        check_eq("issue_out_sel", 32'(bus.alu_out_sel), 32'h04);
      end
      if (n == 2) begin
        check_eq("wait_in_sel", 32'(bus.alu_in_sel), 32'h4);
        check_eq("wait_num1", 32'(bus.alu_num1), 32'h05);
        check_eq("wait_out_sel", 32'(bus.alu_out_sel), 32'h04);
      end
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    check_eq("add_latency", 32'(lat), 32'd3);
    check_eq("add_data", 32'(bus.rsp_data), 32'h08);
    check_eq("add_err", 32'(bus.rsp_error), 32'h0);
    check_eq("resp_out_sel", 32'(bus.alu_out_sel), 32'h0);
    check_eq("resp_num1", 32'(bus.alu_num1), 32'h0);
    tick();
    check_eq("rsp_drop", 32'(bus.rsp_valid), 32'h0);

    // Each opcode
    for (int i = 0; i < 8; i++) begin
      send(v_op[i], v_a[i], v_b[i], 1'b0);
      expect_rsp($sformatf("op%0d_%0d", v_op[i], i), v_res[i], v_err[i]);
    end

    // Chaining, queued back-to-back
    send(3'd4, 8'h02, 8'h03, 1'b0);
    send(3'd4, 8'hEE, 8'h04, 1'b1);
    expect_rsp("chain_first", 8'h05, 1'b0);
    expect_rsp("chain_second", 8'h09, 1'b0);

    // Illegal op: no ALU load, last_res kept (09 + 01 = 0A)
    lc = load_cnt;
    send(3'd7, 8'h11, 8'h22, 1'b0);
    expect_rsp("illegal", 8'h00, 1'b1);
    check_eq("illegal_no_load", 32'(load_cnt), 32'(lc));
    send(3'd4, 8'hEE, 8'h01, 1'b1);
    expect_rsp("chain_after_illegal", 8'h0A, 1'b0);

    // Backpressure: six offered, five accepted
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_op    = 3'd4;
      bus.cmd_a     = 8'(8'h10 + i);
      bus.cmd_b     = 8'h01;
      bus.cmd_chain = 1'b0;
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) accepted++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check_eq("bp_accepted", 32'(accepted), 32'd5);
    check_eq("bp_ready_low", 32'(bus.cmd_ready), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("bp_ready_still_low", 32'(bus.cmd_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      expect_rsp($sformatf("bp_rsp%0d", i), 8'(8'h11 + i), 1'b0);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    check_eq("bp_no_extra", 32'(seen), 32'd0);
    check_eq("bp_idle_busy", 32'(bus.busy), 32'h0);

    // Reset during WAIT with two queued
    bus.rsp_ready = 1'b0;
    bus.cmd_op    = 3'd4;
    bus.cmd_b     = 8'h01;
    bus.cmd_chain = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'h30;
    tick();
    bus.cmd_a     = 8'h31;
    tick();
    bus.cmd_a     = 8'h32;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("pre_rst_busy", 32'(bus.busy), 32'h1);
    check_eq("pre_rst_num1", 32'(bus.alu_num1), 32'h30);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    tick();
    rst = 1'b0;
    check_eq("mid_ready_after_rst", 32'(bus.cmd_ready), 32'h1);
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    check_eq("mid_no_rsp", 32'(seen), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'h0);

    // last_res cleared by reset: chain add 00 + 07
    send(3'd4, 8'hFF, 8'h07, 1'b1);
    expect_rsp("post_rst_chain", 8'h07, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width.
REQ-002 Parameter DEPTH, default 4: command FIFO entries, power of two.
REQ-003 Parameter ALU_LAT, default 1: cycles from ALU input edge to valid alu_result.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO not full.
REQ-008 cmd_op  in  3  0 and, 1 or, 2 xor, 3 not, 4 add, 5 sub, 6 mult, 7 illegal.
REQ-009 cmd_a, cmd_b  in  WIDTH each  operands.
REQ-010 cmd_chain  in  1  use last captured result as A.
REQ-011 alu_on  out  1  ALU enable.
REQ-012 alu_in_sel  out  3  one-hot {persist, load, reset}.
REQ-013 alu_num1, alu_num2  out  WIDTH each  ALU operands.
REQ-014 alu_out_sel  out  7  one-hot {and, or, not, xor, add, sub, mult}, bit 6 = and.
REQ-015 alu_result  in  WIDTH; alu_overflow  in  1  ALU result and overflow.
REQ-016 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-017 rsp_data  out  WIDTH; rsp_error  out  1  response payload.
REQ-018 busy  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-019 Handshake: command accepted on clk edge with cmd_valid&cmd_ready; cmd_ready depends only on registered FIFO count.
REQ-020 FIFO: DEPTH entries {op, a, b, chain}, wrap-around pointers; write and pop in same cycle legal at any count; write ignored when full.
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE pops FIFO when non-empty.
REQ-022 ISSUE (1 cycle): alu_in_sel=load, alu_num1 = chain ? last_res : a, alu_num2 = b, alu_out_sel per op; -> WAIT.
REQ-023 WAIT: hold num/out_sel, alu_in_sel=persist, count ALU_LAT cycles; final edge captures alu_result into rsp_data and last_res, alu_overflow (mult only) into rsp_error; -> RESP.
REQ-024 Op 7: ISSUE skips ALU, goes directly to RESP with rsp_data=0, rsp_error=1, last_res unchanged.
REQ-025 RESP: rsp_valid=1, payload stable until rsp_valid&rsp_ready edge; -> IDLE; no response dropped or duplicated.
REQ-026 Latency, empty FIFO, IDLE: rsp_valid rises ALU_LAT+2 edges after command handshake edge.
REQ-027 Back-to-back throughput: one command per ALU_LAT+3 cycles with rsp_ready held high.
REQ-028 IDLE/RESP drive alu_in_sel=persist, alu_out_sel=0, num=0; alu_on=1 whenever not in reset.
REQ-029 All arithmetic width-truncated to WIDTH by the ALU; sequencer does not modify results.

Reset
REQ-030 rst asserted: immediately FSM=IDLE, FIFO empty, last_res=0, rsp_valid=0, rsp_data=0, rsp_error=0, alu_on=0, alu_in_sel=reset, alu_num*=0, alu_out_sel=0, busy=0.
REQ-031 Reset mid-operation discards in-flight command and queued entries; no response emitted afterward.
REQ-032 cmd_ready=1 on the first cycle after rst deasserts.

Verification
REQ-033 add a=8'h05 b=8'h03, rsp_ready=1 -> rsp_data=8'h08, rsp_error=0, rsp_valid at handshake+3 edges (ALU_LAT=1).
REQ-034 mult a=8'h20 b=8'h10 (ALU overflow=1) -> rsp_error=1, rsp_data=alu_result low 8 bits.
REQ-035 rsp_ready=0, 6 commands offered back-to-back -> 5 accepted, cmd_ready=0 thereafter; releasing rsp_ready returns 5 responses in order.
REQ-036 add 8'h02+8'h03, then chain add b=8'h04 -> responses 8'h05 then 8'h09.
REQ-037 op=7 -> rsp_data=0, rsp_error=1, no ISSUE-driven load on alu_in_sel.
REQ-038 rst pulse during WAIT with 2 queued -> all outputs at REQ-030 values, no rsp_valid until a new command.
